// File: rtl/c1541_track_loader_pkg.sv
// c1541_pkg: shared types and D64 zone geometry for the 1541 track loader.
package c1541_pkg;

  // Loader sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_WR = 3'd1,
    REQ_RD = 3'd2,
    XFER   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Bus widths towards the SD host
  localparam int LBA_W = 32;
  localparam int BLK_W = 6;
  localparam int TRK_W = 6;

  // Watchdog counter width (only used when the watchdog is built in)
  localparam int WDT_W = 24;

  // Last full track of each speed zone
  localparam logic [9:0] ZONE1_END = 10'd17;
  localparam logic [9:0] ZONE2_END = 10'd24;
  localparam logic [9:0] ZONE3_END = 10'd30;

  // 256-byte sectors per track in each zone
  localparam logic [9:0] SPT_Z1 = 10'd21;
  localparam logic [9:0] SPT_Z2 = 10'd19;
  localparam logic [9:0] SPT_Z3 = 10'd18;
  localparam logic [9:0] SPT_Z4 = 10'd17;

  // Absolute sector number of the first track of each zone
  localparam logic [9:0] START_Z1 = 10'd0;
  localparam logic [9:0] START_Z2 = 10'd357;
  localparam logic [9:0] START_Z3 = 10'd490;
  localparam logic [9:0] START_Z4 = 10'd598;

endpackage

// File: rtl/c1541_track_loader_if.sv
// c1541_track_loader_if: block-transfer handshake between the track loader
// (master) and the SD host (slave).
interface c1541_track_loader_if;
  import c1541_pkg::*;

  logic [LBA_W-1:0] sd_lba;
  logic [BLK_W-1:0] sd_blk_cnt;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;

  modport master (
    output sd_lba,
    output sd_blk_cnt,
    output sd_rd,
    output sd_wr,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_blk_cnt,
    input  sd_rd,
    input  sd_wr,
    output sd_ack
  );

endinterface

// File: rtl/c1541_track_loader_geom.sv
// c1541_track_geom: combinational full-track to SD transfer fields.
// Start sector S and sector count N come from the D64 zone table; the
// track is then expressed as 512-byte blocks plus a half-block offset.
module c1541_track_geom
  import c1541_pkg::*;
(
  input  logic [TRK_W-1:0] i_ft,
  output logic [LBA_W-1:0] o_lba,
  output logic [BLK_W-1:0] o_blk_cnt,
  output logic             o_ofs
);

  logic [9:0] w_ft;
  logic [9:0] w_s;
  logic [9:0] w_n;

  // Zone lookup: start sector and sectors per track for this full track
  always_comb begin
    w_ft = {4'd0, i_ft};
    w_s  = START_Z1;
    w_n  = SPT_Z1;
    if (w_ft == 10'd0) begin
      // No track held; fields are don't-care but kept at track 1 values.
      w_s = START_Z1;
      w_n = SPT_Z1;
    end else if (w_ft <= ZONE1_END) begin
      w_s = START_Z1 + (w_ft - 10'd1) * SPT_Z1;
      w_n = SPT_Z1;
    end else if (w_ft <= ZONE2_END) begin
      w_s = START_Z2 + (w_ft - (ZONE1_END + 10'd1)) * SPT_Z2;
      w_n = SPT_Z2;
    end else if (w_ft <= ZONE3_END) begin
      w_s = START_Z3 + (w_ft - (ZONE2_END + 10'd1)) * SPT_Z3;
      w_n = SPT_Z3;
    end else begin
      w_s = START_Z4 + (w_ft - (ZONE3_END + 10'd1)) * SPT_Z4;
      w_n = SPT_Z4;
    end
  end

  // An odd start sector begins halfway into a block and may spill one more
  assign o_lba     = {{(LBA_W-9){1'b0}}, w_s[9:1]};
  assign o_ofs     = w_s[0];
  assign o_blk_cnt = BLK_W'((({9'd0, w_s[0]} + w_n + 10'd1) >> 1) - 10'd1);

endmodule

// File: rtl/c1541_track_loader.sv
// c1541_track_loader: watches the head half-track and the save toggle,
// and sequences SD block reads/writes of whole D64 tracks.
// Optional watchdog: define C1541_TRACK_LOADER_WDT_EN to abort a transfer
// that the SD host never completes and raise the sticky error flag.
module c1541_track_loader
  import c1541_pkg::*;
#(
  parameter int MAX_TRACK = 40
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 change,
  input  logic [6:0]           track,
  input  logic                 save_track,
  c1541_track_loader_if.master sd,
  output logic                 busy,
  output logic [TRK_W-1:0]     loaded_track,
  output logic                 sec_ofs,
  output logic                 error
);

  localparam logic [6:0] MAX_FT = 7'(MAX_TRACK);

  state_t           r_state;
  logic             r_arm;
  logic             r_save_q;
  logic             r_change_q;
  logic             r_save_pend;
  logic             r_reload_pend;
  logic [TRK_W-1:0] r_ft;
  logic [TRK_W-1:0] r_loaded;
  logic [TRK_W-1:0] r_xfer_ft;
  logic [LBA_W-1:0] r_lba;
  logic [BLK_W-1:0] r_blk;
  logic             r_ofs;
  logic             r_rd;
  logic             r_wr;

  logic [6:0]       w_ft_raw;
  logic [TRK_W-1:0] w_ft;
  logic             w_unused_trk0;
  logic             w_save_edge;
  logic             w_change_rise;
  logic             w_do_wr;
  logic             w_do_rd;
  logic             w_enter_wr;
  logic             w_enter_rd;
  logic [TRK_W-1:0] w_geom_ft;
  logic [LBA_W-1:0] w_lba;
  logic [BLK_W-1:0] w_blk;
  logic             w_ofs;

  // Half-track to full track, clamped to the last track in the image
  assign w_ft_raw      = {1'b0, track[6:1]} + 7'd1;
  assign w_ft          = (w_ft_raw > MAX_FT) ? MAX_FT[TRK_W-1:0] : w_ft_raw[TRK_W-1:0];
  assign w_unused_trk0 = track[0];

  // Edges are ignored until the edge registers hold real input values
  assign w_save_edge   = r_arm & (save_track ^ r_save_q);
  assign w_change_rise = r_arm & change & ~r_change_q;

  // IDLE decision: write-back beats reload/track change
  assign w_do_wr    = r_arm & r_save_pend & (r_loaded != '0);
  assign w_do_rd    = r_arm & (r_reload_pend | (r_ft != r_loaded));
  assign w_enter_wr = (r_state == IDLE) & w_do_wr;
  assign w_enter_rd = (r_state == IDLE) & ~w_do_wr & w_do_rd;

  // A write-back always uses the geometry of the track being evicted
  assign w_geom_ft = w_do_wr ? r_loaded : r_ft;

  c1541_track_geom u_geom (
    .i_ft      (w_geom_ft),
    .o_lba     (w_lba),
    .o_blk_cnt (w_blk),
    .o_ofs     (w_ofs)
  );

  // Edge registers and pending flags; a disk change discards any save
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm         <= 1'b0;
      r_save_q      <= 1'b0;
      r_change_q    <= 1'b0;
      r_save_pend   <= 1'b0;
      r_reload_pend <= 1'b1;
      r_ft          <= '0;
    end else begin
      r_arm      <= 1'b1;
      r_save_q   <= save_track;
      r_change_q <= change;
      r_ft       <= w_ft;
      if (w_change_rise) begin
        r_save_pend   <= 1'b0;
        r_reload_pend <= 1'b1;
      end else begin
        if (w_save_edge) begin
          r_save_pend <= 1'b1;
        end else if (w_enter_wr) begin
          r_save_pend <= 1'b0;
        end
        if (w_enter_rd) begin
          r_reload_pend <= 1'b0;
        end
      end
    end
  end

`ifdef C1541_TRACK_LOADER_WDT_EN
  logic [WDT_W-1:0] r_wdt;
  logic             r_error;
  logic             w_wdt_state;
  logic             w_leave;

  assign w_wdt_state = (r_state == REQ_WR) | (r_state == REQ_RD) | (r_state == XFER);
  assign w_leave     = (((r_state == REQ_WR) | (r_state == REQ_RD)) & sd.sd_ack) |
                       ((r_state == XFER) & ~sd.sd_ack);
`endif

  // Transfer sequencer with registered request lines and latched fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_lba     <= '0;
      r_blk     <= '0;
      r_ofs     <= 1'b0;
      r_loaded  <= '0;
      r_xfer_ft <= '0;
`ifdef C1541_TRACK_LOADER_WDT_EN
      r_wdt     <= '0;
      r_error   <= 1'b0;
`endif
    end else begin
`ifdef C1541_TRACK_LOADER_WDT_EN
      if (w_change_rise) begin
        r_error <= 1'b0;
      end
`endif
      case (r_state)
        IDLE: begin
          if (w_enter_wr) begin
            r_state   <= REQ_WR;
            r_wr      <= 1'b1;
            r_lba     <= w_lba;
            r_blk     <= w_blk;
            r_ofs     <= w_ofs;
            r_xfer_ft <= r_loaded;
          end else if (w_enter_rd) begin
            r_state   <= REQ_RD;
            r_rd      <= 1'b1;
            r_lba     <= w_lba;
            r_blk     <= w_blk;
            r_ofs     <= w_ofs;
            r_xfer_ft <= r_ft;
          end
        end
        REQ_WR: begin
          if (sd.sd_ack) begin
            r_wr    <= 1'b0;
            r_state <= XFER;
          end
        end
        REQ_RD: begin
          if (sd.sd_ack) begin
            r_rd    <= 1'b0;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (!sd.sd_ack) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_loaded <= r_xfer_ft;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
        end
      endcase
`ifdef C1541_TRACK_LOADER_WDT_EN
      // Stuck host: abandon the transfer and force a reload via loaded = 0
      if (w_wdt_state) begin
        if (&r_wdt) begin
          r_state  <= IDLE;
          r_rd     <= 1'b0;
          r_wr     <= 1'b0;
          r_error  <= 1'b1;
          r_loaded <= '0;
          r_wdt    <= '0;
        end else if (w_leave) begin
          r_wdt <= '0;
        end else begin
          r_wdt <= r_wdt + 1'b1;
        end
      end else begin
        r_wdt <= '0;
      end
`endif
    end
  end

  assign sd.sd_lba     = r_lba;
  assign sd.sd_blk_cnt = r_blk;
  assign sd.sd_rd      = r_rd;
  assign sd.sd_wr      = r_wr;
  assign loaded_track  = r_loaded;
  assign sec_ofs       = r_ofs;
  assign busy          = (r_state != IDLE) | r_save_pend | r_reload_pend | (w_ft != r_loaded);

`ifdef C1541_TRACK_LOADER_WDT_EN
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_c1541_track_loader.sv
// tb_c1541_track_loader: directed table, corner sequences and randomized
// track/save traffic against a sector-summing geometry model.
module tb_c1541_track_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       change;
  logic [6:0] track;
  logic       save_track;
  logic       busy;
  logic [5:0] loaded_track;
  logic       sec_ofs;
  logic       error;

  c1541_track_loader_if sd_if ();

  c1541_track_loader #(.MAX_TRACK(40)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .change       (change),
    .track        (track),
    .save_track   (save_track),
    .sd           (sd_if),
    .busy         (busy),
    .loaded_track (loaded_track),
    .sec_ofs      (sec_ofs),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit overlap_seen = 1'b0;

  always @(negedge clk) if (sd_if.sd_rd && sd_if.sd_wr) overlap_seen = 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "time limit");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int lba; int cnt; int ofs; } geom_t;

  function automatic int spt(input int t);
    if (t <= 17) return 21;
    if (t <= 24) return 19;
    if (t <= 30) return 18;
    return 17;
  endfunction

  function automatic int ft_of(input int trk);
    int f;
    f = trk / 2 + 1;
    return (f > 40) ? 40 : f;
  endfunction

  // Blocks spanned by sectors S..S+N-1 when two sectors share a block
  function automatic geom_t model(input int ft);
    geom_t g;
    int s;
    int n;
    s = 0;
    for (int t = 1; t < ft; t++) s += spt(t);
    n = spt(ft);
    g.lba = s / 2;
    g.cnt = (s + n - 1) / 2 - s / 2;
    g.ofs = s % 2;
    return g;
  endfunction

  // Serve one request as the SD host; optional stimulus while ack is high
  task automatic do_xfer(input bit exp_wr, input int exp_ft, input string tag,
                         input int mid_track, input bit mid_save, input bit mid_change,
                         output int o_lba, output int o_cnt, output int o_ofs);
    int          waited;
    geom_t       g;
    logic [31:0] lba_s;
    o_lba = -1; o_cnt = -1; o_ofs = -1;
    waited = 0;
    while (!(sd_if.sd_rd || sd_if.sd_wr) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, " req_seen"}, 32'(sd_if.sd_rd || sd_if.sd_wr), 1);
    if (!(sd_if.sd_rd || sd_if.sd_wr)) return;
    g = model(exp_ft);
    chk({tag, " sd_wr"}, 32'(sd_if.sd_wr), 32'(exp_wr));
    chk({tag, " sd_rd"}, 32'(sd_if.sd_rd), 32'(!exp_wr));
    chk({tag, " sd_lba"}, sd_if.sd_lba, g.lba);
    chk({tag, " sd_blk_cnt"}, 32'(sd_if.sd_blk_cnt), g.cnt);
    chk({tag, " sec_ofs"}, 32'(sec_ofs), g.ofs);
    o_lba = int'(sd_if.sd_lba);
    o_cnt = int'(sd_if.sd_blk_cnt);
    o_ofs = int'(sec_ofs);
    lba_s = sd_if.sd_lba;
    sd_if.sd_ack = 1'b1;
    @(negedge clk);
    chk({tag, " req_drop"}, 32'(sd_if.sd_rd || sd_if.sd_wr), 0);
    if (mid_track >= 0) track = 7'(mid_track);
    if (mid_save) save_track = ~save_track;
    @(negedge clk);
    if (mid_change) change = 1'b1;
    @(negedge clk);
    chk({tag, " lba_hold"}, sd_if.sd_lba, lba_s);
    chk({tag, " busy_xfer"}, 32'(busy), 1);
    sd_if.sd_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, " loaded"}, 32'(loaded_track), exp_ft);
  endtask

  typedef struct { int trk; int ft; int lba; int cnt; int ofs; } vec_t;
  vec_t vecs[10];

  int ql, qc, qo;
  int m_loaded;
  int seen;
  int nt, nft, sv;

  initial begin
    vecs[0] = '{0,  1,  0,   10, 0};
    vecs[1] = '{78, 40, 375, 8,  1};
    vecs[2] = '{32, 17, 168, 10, 0};
    vecs[3] = '{2,  2,  10,  10, 1};
    vecs[4] = '{46, 24, 235, 9,  1};
    vecs[5] = '{48, 25, 245, 8,  0};
    vecs[6] = '{58, 30, 290, 8,  0};
    vecs[7] = '{60, 31, 299, 8,  0};
    vecs[8] = '{84, 40, 375, 8,  1};
    vecs[9] = '{34, 18, 178, 9,  1};

    reset_n = 1'b0; change = 1'b0; track = 7'd36; save_track = 1'b0;
    sd_if.sd_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst sd_rd", 32'(sd_if.sd_rd), 0);
    chk("rst sd_wr", 32'(sd_if.sd_wr), 0);
    chk("rst sd_lba", sd_if.sd_lba, 0);
    chk("rst sd_blk_cnt", 32'(sd_if.sd_blk_cnt), 0);
    chk("rst sec_ofs", 32'(sec_ofs), 0);
    chk("rst loaded", 32'(loaded_track), 0);
    chk("rst error", 32'(error), 0);

    // First read starts from the reset-time reload request
    reset_n = 1'b1;
    do_xfer(0, 19, "boot", -1, 0, 0, ql, qc, qo);
    @(negedge clk);
    chk("boot busy", 32'(busy), 0);
    m_loaded = 19;

    for (int i = 0; i < 10; i++) begin
      track = 7'(vecs[i].trk);
      do_xfer(0, vecs[i].ft, $sformatf("vec%0d", i), -1, 0, 0, ql, qc, qo);
      chk($sformatf("vec%0d tbl_lba", i), ql, vecs[i].lba);
      chk($sformatf("vec%0d tbl_cnt", i), qc, vecs[i].cnt);
      chk($sformatf("vec%0d tbl_ofs", i), qo, vecs[i].ofs);
    end

    // Save and track change together: write old track 18, then read 19
    track = 7'd36; save_track = ~save_track;
    do_xfer(1, 18, "same_wr", -1, 0, 0, ql, qc, qo);
    chk("same_wr lba", ql, 178);
    chk("same_wr cnt", qc, 9);
    do_xfer(0, 19, "same_rd", -1, 0, 0, ql, qc, qo);
    chk("same_rd lba", ql, 188);

    // Save toggle to write request takes exactly two clocks
    save_track = ~save_track;
    @(negedge clk);
    chk("lat wr_1clk", 32'(sd_if.sd_wr), 0);
    @(negedge clk);
    chk("lat wr_2clk", 32'(sd_if.sd_wr), 1);
    do_xfer(1, 19, "lat_wr", -1, 0, 0, ql, qc, qo);

    // Track change during a read forces a second read after DONE
    track = 7'd0;
    do_xfer(0, 1, "mid_rd1", 78, 0, 0, ql, qc, qo);
    do_xfer(0, 40, "mid_rd2", -1, 0, 0, ql, qc, qo);

    // Save then disk change during a transfer: no write, reload instead
    track = 7'd36;
    do_xfer(0, 19, "chg_rd1", -1, 1, 1, ql, qc, qo);
    do_xfer(0, 19, "chg_reload", -1, 0, 0, ql, qc, qo);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (sd_if.sd_rd || sd_if.sd_wr) seen++;
    end
    chk("chg no_more_req", seen, 0);
    chk("chg busy", 32'(busy), 0);
    change = 1'b0;
    repeat (3) @(negedge clk);

    // Host never acks: request is held and no error is raised
    track = 7'd60;
    repeat (3) @(negedge clk);
    chk("hold req_up", 32'(sd_if.sd_rd), 1);
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (!sd_if.sd_rd) seen++;
    end
    chk("hold req_drops", seen, 0);
    chk("hold error", 32'(error), 0);
    do_xfer(0, 31, "hold_done", -1, 0, 0, ql, qc, qo);

    // Reset in the middle of a transfer drops everything at once
    track = 7'd2;
    repeat (3) @(negedge clk);
    chk("mrst req_up", 32'(sd_if.sd_rd), 1);
    sd_if.sd_ack = 1'b1;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mrst sd_rd", 32'(sd_if.sd_rd), 0);
    chk("mrst loaded", 32'(loaded_track), 0);
    chk("mrst sd_lba", sd_if.sd_lba, 0);
    @(negedge clk);
    sd_if.sd_ack = 1'b0;
    reset_n = 1'b1;
    do_xfer(0, 2, "mrst_reload", -1, 0, 0, ql, qc, qo);
    m_loaded = 2;

    // Randomized track moves with optional write-back
    for (int it = 0; it < 30; it++) begin
      nt  = int'($urandom_range(0, 127));
      sv  = int'($urandom_range(0, 1));
      nft = ft_of(nt);
      track = 7'(nt);
      if (sv != 0) save_track = ~save_track;
      if (sv != 0) do_xfer(1, m_loaded, $sformatf("rnd%0d_wr", it), -1, 0, 0, ql, qc, qo);
      if (nft != m_loaded) begin
        do_xfer(0, nft, $sformatf("rnd%0d_rd", it), -1, 0, 0, ql, qc, qo);
        m_loaded = nft;
      end else if (sv == 0) begin
        seen = 0;
        repeat (8) begin
          @(negedge clk);
          if (sd_if.sd_rd || sd_if.sd_wr) seen++;
        end
        chk($sformatf("rnd%0d quiet", it), seen, 0);
      end
      repeat (2) @(negedge clk);
      chk($sformatf("rnd%0d loaded", it), 32'(loaded_track), m_loaded);
      chk($sformatf("rnd%0d busy", it), 32'(busy), 0);
    end

    chk("rd_wr overlap", 32'(overlap_seen), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/c1541_track_loader.md
# c1541_track_loader

Sequencer between the 1541 drive core's head-position logic and the SD block interface. It watches the current half-track and the save-request toggle, converts the D64 track geometry into an SD LBA and block count, and runs the read/write handshake against the SD host. While a transfer is in flight it raises `busy`, which the GCR stage uses to stall the bit stream.

## Interface
Parameters:
- MAX_TRACK, default 40: highest full track with an image; higher requests clamp to it.

Ports:
- clk  in  1  drive clock (the same clock as the SD buffer side).
- reset_n  in  1  asynchronous, active-low reset.
- change  in  1  image-mounted level; its rising edge is a disk change.
- track  in  7  head half-track, 0..84.
- save_track  in  1  toggle; each edge requests a write-back of the loaded track.
- sd_ack  in  1  host acknowledge; high for the duration of a transfer.
- sd_lba  out  32  first 512-byte block of the transfer.
- sd_blk_cnt  out  6  number of blocks minus 1.
- sd_rd  out  1  read request.
- sd_wr  out  1  write request.
- busy  out  1  a transfer is pending or active.
- loaded_track  out  6  full track (1..MAX_TRACK) currently held in the buffer; 0 means none.
- sec_ofs  out  1  1 means sector 0 of the track starts at buffer byte 256.
- error  out  1  watchdog abort flag; only present with the macro, see Configuration.

## Operation
- Full track: ft = track[6:1] + 1, clamped to MAX_TRACK.
- Geometry, S = start sector and N = sectors per track (256-byte units):
  - ft 1–17: S = (ft−1)·21, N = 21.
  - ft 18–24: S = 357 + (ft−18)·19, N = 19.
  - ft 25–30: S = 490 + (ft−25)·18, N = 18.
  - ft 31–40: S = 598 + (ft−31)·17, N = 17.
- Transfer fields:
  - sd_lba = S >> 1, zero-extended to 32 bits.
  - sd_blk_cnt = (((S & 1) + N + 1) >> 1) − 1.
  - sec_ofs = S & 1.
  - Compute with 10-bit unsigned arithmetic.
- Fields are latched in the request state and held stable until the transfer ends.
- States:
  - IDLE.
  - REQ_WR: sd_wr = 1, waiting for sd_ack to rise.
  - REQ_RD: sd_rd = 1, waiting for sd_ack to rise.
  - XFER: request dropped, waiting for sd_ack to fall.
  - DONE: one cycle; updates loaded_track and returns to IDLE.
- Decisions in IDLE, checked in this priority order:
  1. Save pending and loaded_track ≠ 0: go to REQ_WR, using the geometry of loaded_track (not the current ft).
  2. Reload pending, or ft ≠ loaded_track: go to REQ_RD with ft.
  3. Otherwise stay in IDLE.
- Pending flags:
  - Save pending is set when save_track differs from its registered copy.
  - Save pending is cleared when REQ_WR is entered.
  - A rising edge of change clears save pending and sets reload pending. The old image is discarded and nothing is written.
  - Reload pending is cleared when REQ_RD is entered.
- Edges during a transfer are recorded and serviced after DONE. An in-flight transfer is never aborted except by the watchdog.
- Save request and track change in the same cycle: write the old track first, then read the new one.
- busy = (state ≠ IDLE) | save pending | reload pending | (ft ≠ loaded_track).

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0; loaded_track = 0.
  - Reload pending = 1, so the first read starts without a stimulus.
  - The save_track and change edge registers load their current input values, so no false edge is seen at reset release.
- Latency:
  - Stimulus edge → request asserted: 2 cycles (edge register, then IDLE decision).
  - sd_ack rise → request low: next cycle.
  - sd_ack fall → DONE: next cycle; back to IDLE one cycle later.
- sd_rd and sd_wr are never high together, and stay high until sd_ack rises.
- A track change during XFER of a read causes a second read after DONE. The stale loaded_track is replaced.
- Reset asserted mid-transfer: the block drops to reset values immediately. The SD host is responsible for completing or abandoning its side.

## Configuration
- C1541_TRACK_LOADER_WDT_EN defined:
  - A 24-bit counter runs in REQ_RD, REQ_WR and XFER, and is cleared on every state change.
  - On reaching all-ones, the block drops the request, sets `error` (sticky until reset or a change edge), sets loaded_track = 0 and returns to IDLE.
  - The normal reload rules then retry.
- Macro undefined:
  - No counter.
  - The `error` port is tied to 0.
  - The block waits indefinitely.

## Structure
- Package c1541_pkg holds:
  - The state enum (IDLE, REQ_WR, REQ_RD, XFER, DONE).
  - The zone boundaries (17, 24, 30), sector counts (21/19/18/17) and zone start sectors (0/357/490/598).
- Sub-module c1541_track_geom: combinational ft → {sd_lba, sd_blk_cnt, sec_ofs}. It is instantiated once, fed by a mux of loaded_track and ft.

## Test plan
- Reset release, track = 36 (ft 19) → sd_rd with sd_lba = 188, sd_blk_cnt = 9, sec_ofs = 0; after the ack cycle, loaded_track = 19 and busy = 0.
- track = 0 → sd_lba = 0, sd_blk_cnt = 10, sec_ofs = 0; track = 78 (ft 40) → sd_lba = 375, sd_blk_cnt = 8, sec_ofs = 1.
- Loaded ft 18, then save_track toggle and track 34→36 in the same cycle:
  - First sd_wr with sd_lba = 178, sd_blk_cnt = 9.
  - Then sd_rd with sd_lba = 188.
  - sd_rd and sd_wr never overlap.
- Save toggle followed by a change edge before IDLE → no sd_wr; sd_rd of the current track.
- track = 84 with MAX_TRACK = 40 → clamps to ft 40 (sd_lba = 375).
- With C1541_TRACK_LOADER_WDT_EN defined and sd_ack held low for 2^24 cycles → request drops, error = 1, loaded_track = 0, and a retry sd_rd follows. Without the macro, the request stays high indefinitely.
